// File: rtl/shift_reg_univ.sv
// Universal shift register with a serial-out burst engine.
// Modes 0-6 are single-edge register operations gated by en. Mode 7 with start
// loads pdata and then shifts it out MSB-first on sout over WIDTH cycles, with
// busy asserted for the whole burst and a one-cycle done pulse at the end.
module shift_reg_univ #(
  parameter int unsigned      WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic [WIDTH-1:0] pdata,
  input  logic             start,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam int unsigned    CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  localparam logic [2:0] ModeHold  = 3'd0;
  localparam logic [2:0] ModeShl   = 3'd1;
  localparam logic [2:0] ModeShr   = 3'd2;
  localparam logic [2:0] ModeRol   = 3'd3;
  localparam logic [2:0] ModeRor   = 3'd4;
  localparam logic [2:0] ModeLoad  = 3'd5;
  localparam logic [2:0] ModeAsr   = 3'd6;
  localparam logic [2:0] ModeBurst = 3'd7;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StShift = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [WIDTH-1:0]  op_result;
  logic [WIDTH-1:0]  burst_shift;

  // Result of the single-edge register operation selected by mode
  always_comb begin
    op_result = q_q;
    case (mode)
      ModeHold:  op_result = q_q;
      ModeShl:   op_result = {q_q[WIDTH-2:0], sin_l};
      ModeShr:   op_result = {sin_r, q_q[WIDTH-1:1]};
      ModeRol:   op_result = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
      ModeRor:   op_result = {q_q[0], q_q[WIDTH-1:1]};
      ModeLoad:  op_result = pdata;
      ModeAsr:   op_result = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
      ModeBurst: op_result = q_q;  // without start, burst select behaves as hold
      default:   op_result = q_q;
    endcase
  end

  // Burst shifting always moves toward the MSB so sout presents data MSB first
  always_comb begin
    burst_shift = {q_q[WIDTH-2:0], sin_l};
  end

  // Next-state logic: burst FSM takes priority over the en-gated mode operations
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    count_d = count_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // start is honoured regardless of en
        if (mode == ModeBurst && start) begin
          q_d     = pdata;
          count_d = CntLast;
          state_d = StLoad;
        end else if (en) begin
          q_d = op_result;
        end
      end
      StLoad: begin
        // First shift edge; the count stays at WIDTH-1 so that WIDTH shift edges
        // in total bring it to zero on edge N+WIDTH
        q_d     = burst_shift;
        state_d = StShift;
      end
      StShift: begin
        q_d = burst_shift;
        if (count_q != '0) begin
          count_d = count_q - CntOne;
        end
        // Leaving on the edge where count reaches zero; <= guards a stuck zero
        if (count_q <= CntOne) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        count_d = '0;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  // All state with asynchronous active-high reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      q_q     <= RST_VAL;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Registered outputs
  always_comb begin
    q    = q_q;
    sout = q_q[WIDTH-1];
    busy = busy_q;
    done = done_q;
  end

endmodule

// File: tb/tb_shift_reg_univ.sv
// Self-checking bench for shift_reg_univ: three instances (WIDTH 4, 8, 32) are
// compared every cycle against a behavioural model, plus directed literal checks.
module tb_shift_reg_univ;

  typedef struct packed {
    logic        en;
    logic [2:0]  mode;
    logic        sin_l;
    logic        sin_r;
    logic        start;
    logic [31:0] pdata;
  } in_t;

  typedef struct {
    logic [31:0] q;
    int          rem;   // burst shift edges still to come
    logic        done;
  } mstate_t;

  logic clk;
  logic rst;
  in_t  i4, i8, i32;

  logic [3:0]  q4;
  logic [7:0]  q8;
  logic [31:0] q32;
  logic        sout4, sout8, sout32;
  logic        busy4, busy8, busy32;
  logic        done4, done8, done32;

  mstate_t m4, m8, m32;

  int total = 0;
  int bad   = 0;

  shift_reg_univ #(.WIDTH(4), .RST_VAL(4'h0)) u4 (
    .clk(clk), .rst(rst), .en(i4.en), .mode(i4.mode), .sin_l(i4.sin_l), .sin_r(i4.sin_r),
    .pdata(i4.pdata[3:0]), .start(i4.start), .q(q4), .sout(sout4), .busy(busy4), .done(done4)
  );

  shift_reg_univ #(.WIDTH(8), .RST_VAL(8'h5A)) u8 (
    .clk(clk), .rst(rst), .en(i8.en), .mode(i8.mode), .sin_l(i8.sin_l), .sin_r(i8.sin_r),
    .pdata(i8.pdata[7:0]), .start(i8.start), .q(q8), .sout(sout8), .busy(busy8), .done(done8)
  );

  shift_reg_univ #(.WIDTH(32), .RST_VAL(32'h0)) u32 (
    .clk(clk), .rst(rst), .en(i32.en), .mode(i32.mode), .sin_l(i32.sin_l),
    .sin_r(i32.sin_r), .pdata(i32.pdata), .start(i32.start), .q(q32), .sout(sout32),
    .busy(busy32), .done(done32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  function automatic mstate_t mreset(input logic [31:0] rv);
    mstate_t s;
    s.q    = rv;
    s.rem  = 0;
    s.done = 1'b0;
    return s;
  endfunction

  function automatic mstate_t step(input mstate_t s, input int w, input in_t in);
    mstate_t     n;
    logic [31:0] mask;
    logic [31:0] msb;
    mask   = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    msb    = 32'd1 << (w - 1);
    n      = s;
    n.done = 1'b0;
    if (s.rem > 0) begin
      n.q   = ((s.q << 1) | 32'(in.sin_l)) & mask;
      n.rem = s.rem - 1;
      if (n.rem == 0) n.done = 1'b1;
    end else if (in.mode == 3'd7 && in.start) begin
      n.q   = in.pdata & mask;
      n.rem = w;
    end else if (in.en) begin
      case (in.mode)
        3'd1:    n.q = ((s.q << 1) | 32'(in.sin_l)) & mask;
        3'd2:    n.q = (s.q >> 1) | (in.sin_r ? msb : 32'd0);
        3'd3:    n.q = ((s.q << 1) | ((s.q & msb) != 0 ? 32'd1 : 32'd0)) & mask;
        3'd4:    n.q = (s.q >> 1) | (s.q[0] ? msb : 32'd0);
        3'd5:    n.q = in.pdata & mask;
        3'd6:    n.q = (s.q >> 1) | (s.q & msb);
        default: n.q = s.q;
      endcase
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m4  <= mreset(32'h0);
      m8  <= mreset(32'h5A);
      m32 <= mreset(32'h0);
    end else begin
      m4  <= step(m4, 4, i4);
      m8  <= step(m8, 8, i8);
      m32 <= step(m32, 32, i32);
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_inst(input string nm, input int w, input logic [31:0] aq, input logic so,
                          input logic bz, input logic dn, input mstate_t m);
    logic [31:0] mq;
    mq = m.q;
    chk({nm, ".q"}, aq, mq);
    chk({nm, ".sout"}, 32'(so), 32'(mq[w-1]));
    chk({nm, ".busy"}, 32'(bz), (m.rem > 0) ? 32'd1 : 32'd0);
    chk({nm, ".done"}, 32'(dn), 32'(m.done));
  endtask

  // Per-cycle comparison against the model, away from the rising edge
  always @(negedge clk) begin
    chk_inst("u4", 4, 32'(q4), sout4, busy4, done4, m4);
    chk_inst("u8", 8, 32'(q8), sout8, busy8, done8, m8);
    chk_inst("u32", 32, q32, sout32, busy32, done32, m32);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic burst8(input logic [7:0] pd, input bit lock, input string nm);
    logic [7:0] sbits;
    int         busy_n;
    int         done_n;
    i8.en    = 1'b0;
    i8.mode  = 3'd7;
    i8.pdata = 32'(pd);
    i8.sin_l = 1'b0;
    i8.start = 1'b1;
    tick();
    i8.start = 1'b0;
    if (lock) begin
      i8.mode  = 3'd5;
      i8.pdata = 32'hFF;
      i8.en    = 1'b1;
    end else begin
      i8.mode = 3'd0;
    end
    chk({nm, "_load"}, 32'(q8), 32'(pd));
    sbits  = '0;
    busy_n = 0;
    done_n = 0;
    for (int k = 0; k < 8; k++) begin
      if (k == 1) chk({nm, "_first_shift"}, 32'(q8), 32'({pd[6:0], 1'b0}));
      sbits  = {sbits[6:0], sout8};
      busy_n += int'(busy8);
      done_n += int'(done8);
      tick();
    end
    chk({nm, "_sout_seq"}, 32'(sbits), 32'(pd));
    chk({nm, "_busy_cycles"}, busy_n, 32'd8);
    chk({nm, "_no_early_done"}, done_n, 32'd0);
    chk({nm, "_done_pulse"}, 32'(done8), 32'd1);
    chk({nm, "_idle_at_done"}, 32'(busy8), 32'd0);
    i8.en   = 1'b0;
    i8.mode = 3'd0;
    tick();
    chk({nm, "_done_single"}, 32'(done8), 32'd0);
  endtask

  initial begin
    int          pat[4];
    logic [3:0]  exp4[4];
    pat  = '{1, 0, 1, 1};
    exp4 = '{4'h1, 4'h2, 4'h5, 4'hB};
    i4   = '0;
    i8   = '0;
    i32  = '0;
    rst  = 1'b1;

    // Reset values
    #12;
    chk("rst_q8", 32'(q8), 32'h5A);
    chk("rst_busy8", 32'(busy8), 32'd0);
    chk("rst_done8", 32'(done8), 32'd0);
    chk("rst_q4", 32'(q4), 32'h0);
    @(posedge clk);
    #2 rst = 1'b0;

    // Left shift chain on WIDTH=4
    i4.en   = 1'b1;
    i4.mode = 3'd1;
    for (int i = 0; i < 4; i++) begin
      i4.sin_l = pat[i][0];
      tick();
      chk("lshift_chain", 32'(q4), 32'(exp4[i]));
    end

    // All modes on WIDTH=4 and WIDTH=32, checked by the model
    i32.en = 1'b1;
    for (int m = 1; m <= 6; m++) begin
      for (int k = 0; k < 3; k++) begin
        i4.mode   = 3'(m);
        i4.sin_l  = k[0];
        i4.sin_r  = ~k[0];
        i4.pdata  = 32'(m + 6);
        i32.mode  = 3'(m);
        i32.sin_l = ~k[0];
        i32.sin_r = k[0];
        i32.pdata = 32'h9ABC_0000 ^ 32'(m * 32'h1357);
        tick();
      end
    end
    i4.en  = 1'b0;
    i32.en = 1'b0;

    // Rotate right restores, arithmetic shift right sign-fills
    i8.en    = 1'b1;
    i8.mode  = 3'd5;
    i8.pdata = 32'hA5;
    tick();
    chk("load_a5", 32'(q8), 32'hA5);
    i8.mode = 3'd4;
    tick();
    chk("rotr_1", 32'(q8), 32'hD2);
    repeat (7) tick();
    chk("rotr_8", 32'(q8), 32'hA5);
    i8.mode  = 3'd5;
    i8.pdata = 32'h80;
    tick();
    i8.mode = 3'd6;
    repeat (3) tick();
    chk("asr_3", 32'(q8), 32'hF0);

    // Hold with en=0 while every input toggles
    i8.mode  = 3'd5;
    i8.pdata = 32'h3C;
    tick();
    i8.en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      i8.mode  = 3'(k % 8);
      i8.sin_l = k[0];
      i8.sin_r = k[1];
      i8.pdata = 32'($urandom_range(0, 255));
      tick();
      chk("hold_en0", 32'(q8), 32'h3C);
    end

    // Burst, then burst with lockout attempts
    burst8(8'hC3, 1'b0, "burst");
    chk("burst_bits_literal", 32'(q8), 32'h00);
    burst8(8'hC3, 1'b1, "lockout");
    burst8(8'h96, 1'b1, "lockout96");

    // start held high across the end of a burst relaunches on the first idle edge
    i8.mode  = 3'd7;
    i8.pdata = 32'hC3;
    i8.start = 1'b1;
    tick();
    i8.pdata = 32'h3C;
    repeat (8) tick();
    chk("relaunch_done", 32'(done8), 32'd1);
    chk("relaunch_idle", 32'(busy8), 32'd0);
    tick();
    chk("relaunch_busy", 32'(busy8), 32'd1);
    chk("relaunch_load", 32'(q8), 32'h3C);
    i8.start = 1'b0;
    i8.mode  = 3'd0;
    repeat (9) tick();
    chk("relaunch_end", 32'(busy8), 32'd0);

    // Asynchronous reset mid-burst
    i8.mode  = 3'd7;
    i8.pdata = 32'hC3;
    i8.start = 1'b1;
    tick();
    i8.start = 1'b0;
    i8.mode  = 3'd0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    chk("arst_q", 32'(q8), 32'h5A);
    chk("arst_busy", 32'(busy8), 32'd0);
    chk("arst_done", 32'(done8), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("post_rst_no_done", 32'(done8), 32'd0);
      chk("post_rst_idle", 32'(busy8), 32'd0);
    end

    // WIDTH=32 rotate left 32 times
    i32.en    = 1'b1;
    i32.mode  = 3'd5;
    i32.pdata = 32'hDEAD_BEEF;
    tick();
    i32.mode = 3'd3;
    tick();
    chk("rotl32_1", q32, 32'hBD5B_7DDF);
    repeat (31) tick();
    chk("rotl32_32", q32, 32'hDEAD_BEEF);
    i32.en = 1'b0;

    // WIDTH=4 burst launched with en=0, checked by the model
    i4.en    = 1'b0;
    i4.mode  = 3'd7;
    i4.pdata = 32'h9;
    i4.sin_l = 1'b1;
    i4.start = 1'b1;
    tick();
    i4.start = 1'b0;
    repeat (6) tick();
    chk("w4_burst_idle", 32'(busy4), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a hung run
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
